nunchuk_responder: RTL and testbench

- I2C target that emulates a Wii Nunchuk at 7-bit address 0x52.
- Packs stick, accelerometer and button values into the standard 6-byte report and serves it to an I2C initiator.
- Does the reverse of the nunchuk byte decoder, so the I2C master path can be exercised in the FPGA without real hardware.
- Runs on the system clock; oversamples SCL/SDA.

---
 rtl/nunchuk_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_nunchuk_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nunchuk_responder.sv
`default_nettype none
// ============================================================================
//  Module      : nunchuk_responder
//  Description : I2C target that emulates a Wii Nunchuk. It packs the stick,
//                accelerometer and button values into the 6-byte report and
//                serves that report to an I2C initiator. SCL and SDA are
//                oversampled on the system clock. Only SDA is driven, as an
//                open-drain low. There is no clock stretching.
//  Revision    : 1.0 - initial release
// ============================================================================
module nunchuk_responder #(
    parameter logic [6:0]  DEV_ADDR  = 7'h52,
    parameter int unsigned NUM_BYTES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       z,
    input  logic       c,
    output logic       busy,
    output logic       read_done
);

    // Reads at or beyond this pointer value return 8'hFF.
    localparam logic [7:0] c_NUM_BYTES = 8'(NUM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and one history stage per line.
    // These reset to 1 so that an idle bus produces no false edges.
    // ------------------------------------------------------------------
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = scl_s2_q & ~scl_h_q;
    assign w_scl_fall = ~scl_s2_q & scl_h_q;
    // START and STOP are SDA transitions while SCL is stable high.
    assign w_start    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign w_stop     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    // ------------------------------------------------------------------
    // Report assembly. This is the inverse of the nunchuk byte decoder.
    // ------------------------------------------------------------------
    logic [5:0][7:0] w_report;

    assign w_report[0] = stick_x;
    assign w_report[1] = stick_y;
    assign w_report[2] = accel_x[9:2];
    assign w_report[3] = accel_y[9:2];
    assign w_report[4] = accel_z[9:2];
    assign w_report[5] = {accel_z[1:0], accel_y[1:0], accel_x[1:0], c, z};

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      tx_q;
    logic [7:0]      ptr_q;
    logic [5:0][7:0] snap_q;
    logic            rw_q;
    logic            first_q;
    logic            ack_phase_q;
    logic            sda_oe_q;
    logic            busy_q;
    logic            read_done_q;

    logic [7:0]      w_shift_next;
    logic [7:0]      w_rd_byte;

    assign w_shift_next = {shift_q[6:0], sda_s2_q};

    // Select the byte at the pointer from the snapshot. Out-of-range reads give FF.
    always_comb begin
        w_rd_byte = 8'hFF;
        if (ptr_q < c_NUM_BYTES) begin
            case (ptr_q)
                8'd0:    w_rd_byte = snap_q[0];
                8'd1:    w_rd_byte = snap_q[1];
                8'd2:    w_rd_byte = snap_q[2];
                8'd3:    w_rd_byte = snap_q[3];
                8'd4:    w_rd_byte = snap_q[4];
                8'd5:    w_rd_byte = snap_q[5];
                default: w_rd_byte = 8'hFF;
            endcase
        end
    end

    // Target FSM. Bits are sampled on SCL rise, and SDA is updated only after an SCL fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            snap_q      <= '0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            read_done_q <= 1'b0;
        end else begin
            read_done_q <= 1'b0;
            if (w_stop) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (w_start) begin
                // A repeated START keeps the pointer, so the initiator can seek and then read.
                state_q   <= ST_ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sda_oe_q <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            shift_q <= w_shift_next;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                if (w_shift_next[7:1] == DEV_ADDR) begin
                                    state_q     <= ST_ADDR_ACK;
                                    ack_phase_q <= 1'b0;
                                    rw_q        <= w_shift_next[0];
                                    first_q     <= 1'b1;
                                    busy_q      <= 1'b1;
                                    // Freeze the report so that the whole read is coherent.
                                    if (w_shift_next[0]) begin
                                        snap_q <= w_report;
                                    end
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // Both ACK states: drive low on the first fall, then hand SDA back on the second fall.
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= 1'b1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                ack_phase_q <= 1'b0;
                                if ((state_q == ST_ADDR_ACK) && rw_q) begin
                                    // The release fall also presents bit 7 of the first read byte.
                                    tx_q      <= w_rd_byte;
                                    sda_oe_q  <= ~w_rd_byte[7];
                                    bit_cnt_q <= 4'd1;
                                    state_q   <= ST_RD_BYTE;
                                end else begin
                                    sda_oe_q  <= 1'b0;
                                    bit_cnt_q <= 4'd0;
                                    state_q   <= ST_WR_BYTE;
                                end
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (w_scl_rise) begin
                            shift_q <= w_shift_next;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q   <= 4'd0;
                                ack_phase_q <= 1'b0;
                                state_q     <= ST_WR_ACK;
                                // The first data byte is the register pointer. Later bytes are discarded.
                                if (first_q) begin
                                    ptr_q   <= w_shift_next;
                                    first_q <= 1'b0;
                                end else begin
                                    ptr_q <= ptr_q + 8'd1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // bit_cnt_q counts the bits already presented. A value of 0 means load the next byte.
                    ST_RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (bit_cnt_q == 4'd0) begin
                                tx_q      <= w_rd_byte;
                                sda_oe_q  <= ~w_rd_byte[7];
                                bit_cnt_q <= 4'd1;
                            end else if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_RD_ACK;
                            end else begin
                                sda_oe_q  <= ~tx_q[6];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            ptr_q <= ptr_q + 8'd1;
                            if (!sda_s2_q) begin
                                bit_cnt_q <= 4'd0;
                                state_q   <= ST_RD_BYTE;
                            end else begin
                                read_done_q <= 1'b1;
                                state_q     <= ST_IGNORE;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end

                    default: begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign read_done = read_done_q;

endmodule
`default_nettype wire

// File: tb/tb_nunchuk_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nunchuk_responder
//  Description : Directed testbench for nunchuk_responder. It contains an
//                I2C initiator model with an open-drain SDA line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nunchuk_responder;

    localparam int c_Q = 60;  // quarter bit period in ns

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] stick_x, stick_y;
    logic [9:0] accel_x, accel_y, accel_z;
    logic       z, c;
    logic       busy, read_done;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int oe_hits = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    nunchuk_responder dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .stick_x   (stick_x),
        .stick_y   (stick_y),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .accel_z   (accel_z),
        .z         (z),
        .c         (c),
        .busy      (busy),
        .read_done (read_done)
    );

    // Count read_done pulses and cycles in which SDA is driven.
    always @(posedge clk) begin
        if (read_done === 1'b1) rd_pulses++;
        if (sda_oe === 1'b1) oe_hits++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        sda_m = b;
        #c_Q;
        scl_m = 1'b1;
        #c_Q;
        s = sda_line;
        #c_Q;
        scl_m = 1'b0;
        #c_Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #c_Q;
        scl_m = 1'b1;
        #c_Q;
        sda_m = 1'b0;
        #c_Q;
        scl_m = 1'b0;
        #c_Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #c_Q;
        scl_m = 1'b1;
        #c_Q;
        sda_m = 1'b1;
        #c_Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, s);
            d = {d[6:0], s};
        end
        i2c_bit(nack, s);
    endtask

    logic       ack;
    logic [7:0] d;
    logic [7:0] exp_rd [6];
    int         base;

    initial begin
        exp_rd = '{8'h80, 8'h7F, 8'hA9, 8'h70, 8'hFF, 8'hF6};
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        stick_x = 8'h80;
        stick_y = 8'h7F;
        accel_x = 10'h2A5;
        accel_y = 10'h1C3;
        accel_z = 10'h3FF;
        z = 1'b0;
        c = 1'b1;
        #52;
        chk("reset_sda_oe", 32'(sda_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_read_done", 32'(read_done), 32'd0);
        #50;
        reset = 1'b0;
        #100;

        // Write the pointer as 0x00.
        i2c_start();
        write_byte(8'hA4, ack);
        chk("wr_addr_ack", 32'(ack), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        write_byte(8'h00, ack);
        chk("wr_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        #c_Q;
        chk("wr_busy_after_stop", 32'(busy), 32'd0);

        // Six-byte read with NACK on the last byte.
        base = rd_pulses;
        i2c_start();
        write_byte(8'hA5, ack);
        chk("rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 6; i++) begin
            read_byte(i == 5, d);
            chk($sformatf("rd_byte%0d", i), 32'(d), 32'(exp_rd[i]));
        end
        chk("rd_busy_after_nack", 32'(busy), 32'd1);
        i2c_stop();
        #c_Q;
        chk("rd_done_pulses", 32'(rd_pulses - base), 32'd1);
        chk("rd_busy_after_stop", 32'(busy), 32'd0);

        // Wrong address: no ACK, and SDA is never driven.
        base = oe_hits;
        i2c_start();
        write_byte(8'hA6, ack);
        chk("bad_addr_nack", 32'(ack), 32'd0);
        write_byte(8'h00, ack);
        chk("bad_addr_data_nack", 32'(ack), 32'd0);
        chk("bad_addr_busy", 32'(busy), 32'd0);
        i2c_stop();
        #c_Q;
        chk("bad_addr_oe_cycles", 32'(oe_hits - base), 32'd0);

        // Snapshot coherence: inputs change after byte 0.
        i2c_start();
        write_byte(8'hA4, ack);
        write_byte(8'h00, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA5, ack);
        read_byte(1'b0, d);
        chk("snap_byte0", 32'(d), 32'h80);
        stick_x = 8'h10;
        z = 1'b1;
        for (int i = 1; i < 6; i++) read_byte(i == 5, d);
        chk("snap_byte5", 32'(d), 32'hF6);
        i2c_stop();
        i2c_start();
        write_byte(8'hA4, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA5, ack);
        chk("rs_addr_ack", 32'(ack), 32'd1);
        read_byte(1'b1, d);
        chk("snap_next_byte0", 32'(d), 32'h10);
        i2c_stop();
        z = 1'b0;

        // Pointer 5, repeated START, read three bytes.
        i2c_start();
        write_byte(8'hA4, ack);
        write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'hA5, ack);
        read_byte(1'b0, d);
        chk("ptr5_byte0", 32'(d), 32'hF6);
        read_byte(1'b0, d);
        chk("ptr5_byte1", 32'(d), 32'hFF);
        read_byte(1'b1, d);
        chk("ptr5_byte2", 32'(d), 32'hFF);
        i2c_stop();
        #c_Q;

        // Asynchronous reset while SDA is driven low (bit 7 of 0x10 is 0).
        i2c_start();
        write_byte(8'hA4, ack);
        write_byte(8'h00, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA5, ack);
        chk("pre_reset_oe", 32'(sda_oe), 32'd1);
        #4;
        reset = 1'b1;
        #1;
        chk("async_reset_oe", 32'(sda_oe), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        #25;
        chk("reset_busy_mid", 32'(busy), 32'd0);
        reset = 1'b0;
        #100;
        chk("post_reset_busy", 32'(busy), 32'd0);
        i2c_start();
        write_byte(8'hA5, ack);
        chk("post_reset_ack", 32'(ack), 32'd1);
        read_byte(1'b1, d);
        chk("post_reset_byte0", 32'(d), 32'h10);
        i2c_stop();
        #c_Q;
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
